// File: rtl/spi_packet_master.sv
// SPI mode-0 packet master: one CS-framed packet of 1..MAX_BYTES bytes, MSB-first, full duplex.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input (MISO sampled from the internal MOSI register).
`timescale 1ns/1ps
module spi_packet_master #(
    parameter int CLK_FREQ      = 25000000,
    parameter int SPI_FREQ      = 2500000,
    parameter int MAX_BYTES     = 9,
    parameter int CS_GAP_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] num_bytes,
    input  logic [7:0] tx_byte,
    output logic       tx_req,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    localparam int H       = CLK_FREQ / (2 * SPI_FREQ);
    localparam int CNT_MAX = (2 * H > CS_GAP_CYCLES) ? 2 * H : CS_GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LEAD_LAST = CW'(2 * H - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] REQ_AT    = CW'(H - 2);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP_CYCLES - 1);
    localparam logic [CW-1:0] DONE_AT   = CW'(CS_GAP_CYCLES - 2);
    localparam bit            GAP_ONE   = (CS_GAP_CYCLES == 1);
    localparam logic [3:0]    MAX_LEN   = 4'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, LEAD, BIT_LO, BIT_HI, TRAIL, GAP} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [3:0]      byte_q;
    logic [3:0]      len_q;
    logic [6:0]      tx_sh_q;
    logic [6:0]      rx_sh_q;
    logic            load_pend_q;
    logic            cs_q, sclk_q, mosi_q, busy_q, done_q, tx_req_q, rx_valid_q;
    logic [7:0]      rx_byte_q;
    logic            miso_meta_q, miso_sync_q;
    logic            miso_d;
    logic [3:0]      len_d;
    logic            last_byte;

    assign len_d     = (num_bytes > MAX_LEN) ? MAX_LEN : num_bytes;
    assign last_byte = (byte_q == (len_q - 4'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= spi_miso;
            miso_sync_q <= miso_meta_q;
        end
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso_d = loopback ? mosi_q : miso_sync_q;
`else
    assign miso_d = miso_sync_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd7;
            byte_q      <= '0;
            len_q       <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            load_pend_q <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_req_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_byte_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            tx_req_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            cnt_q      <= cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start && num_bytes != 4'd0) begin
                        state_q <= LEAD;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        mosi_q  <= tx_byte[7];
                        tx_sh_q <= tx_byte[6:0];
                        len_q   <= len_d;
                        byte_q  <= '0;
                        bit_q   <= 3'd7;
                    end
                end
                LEAD: begin
                    if (cnt_q == LEAD_LAST) begin
                        state_q <= BIT_LO;
                        cnt_q   <= '0;
                    end
                end
                BIT_LO: begin
                    // Next byte arrives one cycle after tx_req, inside this low phase.
                    if (load_pend_q) begin
                        mosi_q      <= tx_byte[7];
                        tx_sh_q     <= tx_byte[6:0];
                        load_pend_q <= 1'b0;
                    end
                    if (cnt_q == HALF_LAST) begin
                        state_q <= BIT_HI;
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                    end
                end
                BIT_HI: begin
                    if (bit_q == 3'd0 && cnt_q == REQ_AT && !last_byte)
                        tx_req_q <= 1'b1;
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b0;
                        rx_sh_q <= {rx_sh_q[5:0], miso_d};
                        bit_q   <= bit_q - 3'd1;
                        if (bit_q != 3'd0) begin
                            state_q <= BIT_LO;
                            mosi_q  <= tx_sh_q[6];
                            tx_sh_q <= {tx_sh_q[5:0], 1'b0};
                        end else begin
                            rx_byte_q  <= {rx_sh_q, miso_d};
                            rx_valid_q <= 1'b1;
                            if (last_byte) begin
                                state_q <= TRAIL;
                            end else begin
                                state_q     <= BIT_LO;
                                byte_q      <= byte_q + 4'd1;
                                load_pend_q <= 1'b1;
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (cnt_q == HALF_LAST) begin
                        state_q <= GAP;
                        cnt_q   <= '0;
                        cs_q    <= 1'b1;
                        mosi_q  <= 1'b0;
                        if (GAP_ONE) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    // done/busy are registered, so they are set one cycle ahead of the last gap cycle.
                    if (!GAP_ONE && cnt_q == DONE_AT) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    if (cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_req   = tx_req_q;
    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs   = cs_q;

endmodule

// File: tb/tb_spi_packet_master.sv
// Bench for spi_packet_master: table-driven packets against a mode-0 slave model plus reset/corner sequences.
`timescale 1ns/1ps
module tb_spi_packet_master;
    localparam int GAP = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] num_bytes = 4'd0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_req, rx_valid, busy, done, spi_clk, spi_mosi, spi_cs;
    logic [7:0] rx_byte;
    logic       miso_r = 1'b0;
    logic       miso_hold0 = 1'b0;
    logic       spi_miso;
    assign spi_miso = miso_hold0 ? 1'b0 : miso_r;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    always #20 clk = ~clk;

    spi_packet_master #(
        .CLK_FREQ(25000000), .SPI_FREQ(2500000), .MAX_BYTES(9), .CS_GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes), .tx_byte(tx_byte),
        .tx_req(tx_req), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy), .done(done),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs)
`ifdef SPI_MASTER_LOOPBACK_EN
        , .loopback(loopback)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Mode-0 slave model: samples MOSI on rising SCLK, shifts MISO on falling SCLK.
    logic [7:0] resp [0:15];
    logic [7:0] s_tx, s_rx;
    int         s_idx, s_bits;
    logic [7:0] slog [$];

    always @(negedge spi_cs) begin
        s_bits = 0;
        s_tx   = resp[0];
        s_idx  = 1;
        miso_r = s_tx[7];
    end

    always @(posedge spi_clk) if (spi_cs === 1'b0) begin
        s_rx = {s_rx[6:0], spi_mosi};
        s_bits++;
        if (s_bits == 8) begin
            slog.push_back(s_rx);
            s_bits = 0;
        end
    end

    always @(negedge spi_clk) if (spi_cs === 1'b0) begin
        if (s_bits == 0) begin
            s_tx = (s_idx < 16) ? resp[s_idx] : 8'h00;
            s_idx++;
        end else begin
            s_tx = {s_tx[6:0], 1'b0};
        end
        miso_r = s_tx[7];
    end

    time t_prev = 0, t_last = 0;
    always @(posedge spi_clk) begin
        t_prev = t_last;
        t_last = $time;
    end

    logic [7:0] txb [0:15];
    logic [7:0] rxq [$];
    int c_req, c_rxv, c_done, c_csl, c_busy;

    task automatic run_pkt(input logic [3:0] nb, input int budget, input int inject_at, input bit start_in_done);
        int k;
        bit pend;
        bit got;
        c_req = 0; c_rxv = 0; c_done = 0; c_csl = 0; c_busy = 0;
        rxq.delete();
        slog.delete();
        k = 1; pend = 0; got = 0;
        @(posedge clk); #1;
        start = 1'b1; num_bytes = nb; tx_byte = txb[0];
        @(posedge clk); #1;
        start = 1'b0; tx_byte = 8'hEE;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (spi_cs === 1'b0) c_csl++;
            if (busy === 1'b1) c_busy++;
            if (tx_req === 1'b1) begin c_req++; pend = 1; end
            if (rx_valid === 1'b1) begin c_rxv++; rxq.push_back(rx_byte); end
            if (done === 1'b1) begin
                c_done++;
                got = 1;
                if (start_in_done) begin start = 1'b1; num_bytes = 4'd1; end
            end
            @(posedge clk); #1;
            start = (c + 1 == inject_at);
            if (start) num_bytes = 4'd9;
            tx_byte = (pend && k < 16) ? txb[k] : 8'hEE;
            if (pend) k++;
            pend = 0;
        end
    endtask

    task automatic chk_bytes(input string name, input int n, input logic [71:0] exp, input bit from_slave);
        logic [7:0] got;
        for (int j = 0; j < n; j++) begin
            if (from_slave) got = (j < slog.size()) ? slog[j] : 8'bx;
            else            got = (j < rxq.size())  ? rxq[j]  : 8'bx;
            chk8($sformatf("%s[%0d]", name, j), got, exp[71-8*j -: 8]);
        end
    endtask

    typedef struct packed {
        logic [3:0]  nb;
        logic [3:0]  n;
        logic [71:0] tx;
        logic [71:0] rsp;
        logic [71:0] rx;
        logic [15:0] csl;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{nb:4'd5,  n:4'd5, tx:72'h12_00_A0_00_D0_00_00_00_00,
                    rsp:72'h5A_A5_3C_C3_FF_00_00_00_00, rx:72'h5A_A5_3C_C3_FF_00_00_00_00, csl:16'd415};
        vecs[1] = '{nb:4'd5,  n:4'd5, tx:72'h30_00_00_00_00_00_00_00_00,
                    rsp:72'h77_A0_00_D0_00_00_00_00_00, rx:72'h77_A0_00_D0_00_00_00_00_00, csl:16'd415};
        vecs[2] = '{nb:4'd9,  n:4'd9, tx:72'h22_00_00_00_00_00_00_00_00,
                    rsp:72'h55_00_00_01_EC_FF_FF_F8_E0, rx:72'h55_00_00_01_EC_FF_FF_F8_E0, csl:16'd735};
        vecs[3] = '{nb:4'd15, n:4'd9, tx:72'h01_02_03_04_05_06_07_08_09,
                    rsp:72'h81_82_83_84_85_86_87_88_89, rx:72'h81_82_83_84_85_86_87_88_89, csl:16'd735};
        vecs[4] = '{nb:4'd1,  n:4'd1, tx:72'hA5_00_00_00_00_00_00_00_00,
                    rsp:72'h3C_00_00_00_00_00_00_00_00, rx:72'h3C_00_00_00_00_00_00_00_00, csl:16'd95};
        for (int j = 0; j < 16; j++) begin txb[j] = 8'h00; resp[j] = 8'h00; end

        // Reset state
        @(negedge clk);
        chk1("rst_cs", spi_cs, 1'b1);
        chk1("rst_sclk", spi_clk, 1'b0);
        chk1("rst_mosi", spi_mosi, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_txreq", tx_req, 1'b0);
        chk1("rst_rxvalid", rx_valid, 1'b0);
        chk8("rst_rxbyte", rx_byte, 8'h00);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 16; j++) begin
                txb[j]  = (j < 9) ? vecs[i].tx[71-8*j -: 8] : 8'h00;
                resp[j] = (j < 9) ? vecs[i].rsp[71-8*j -: 8] : 8'h00;
            end
            run_pkt(vecs[i].nb, 2000, -1, 1'b0);
            chki($sformatf("v%0d_done", i), c_done, 1);
            chki($sformatf("v%0d_txreq", i), c_req, int'(vecs[i].n) - 1);
            chki($sformatf("v%0d_rxvalid", i), c_rxv, int'(vecs[i].n));
            chki($sformatf("v%0d_cslow", i), c_csl, int'(vecs[i].csl));
            chki($sformatf("v%0d_busy", i), c_busy, int'(vecs[i].csl) + GAP - 1);
            chki($sformatf("v%0d_slvcnt", i), slog.size(), int'(vecs[i].n));
            chk_bytes($sformatf("v%0d_mosi", i), int'(vecs[i].n), vecs[i].tx, 1'b1);
            chk_bytes($sformatf("v%0d_rx", i), int'(vecs[i].n), vecs[i].rx, 1'b0);
            if (i == 0) chki("sclk_period_ns", int'(t_last - t_prev), 400);
            @(negedge clk);
            chk1($sformatf("v%0d_idle_cs", i), spi_cs, 1'b1);
        end

        // Reset during LEAD
        txb[0] = 8'h80; txb[1] = 8'h00;
        @(posedge clk); #1; start = 1'b1; num_bytes = 4'd2; tx_byte = txb[0];
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk1("lead_mosi_before", spi_mosi, 1'b1);
        #1; rst = 1'b1;
        #1;
        chk1("lead_rst_cs", spi_cs, 1'b1);
        chk1("lead_rst_sclk", spi_clk, 1'b0);
        chk1("lead_rst_mosi", spi_mosi, 1'b0);
        chk1("lead_rst_busy", busy, 1'b0);
        @(posedge clk); #5; rst = 1'b0;
        c_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) c_done++;
        end
        chki("lead_rst_nodone", c_done, 0);

        // Reset in the middle of a byte while SCLK is high
        txb[0] = 8'hFF;
        @(posedge clk); #1; start = 1'b1; num_bytes = 4'd2; tx_byte = txb[0];
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 100 && spi_clk !== 1'b1; c++) @(negedge clk);
        chk1("byte_sclk_high", spi_clk, 1'b1);
        chk1("byte_mosi_before", spi_mosi, 1'b1);
        #1; rst = 1'b1;
        #1;
        chk1("byte_rst_cs", spi_cs, 1'b1);
        chk1("byte_rst_sclk", spi_clk, 1'b0);
        chk1("byte_rst_mosi", spi_mosi, 1'b0);
        @(posedge clk); #5; rst = 1'b0;
        c_done = 0; c_rxv = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) c_done++;
            if (rx_valid === 1'b1) c_rxv++;
        end
        chki("byte_rst_nodone", c_done, 0);
        chki("byte_rst_norx", c_rxv, 0);

        // Clean packet after the aborted ones
        txb[0] = 8'hA5; resp[0] = 8'h3C;
        run_pkt(4'd1, 500, -1, 1'b0);
        chki("post_rst_done", c_done, 1);
        chk_bytes("post_rst_mosi", 1, 72'hA5_00_00_00_00_00_00_00_00, 1'b1);
        chk_bytes("post_rst_rx", 1, 72'h3C_00_00_00_00_00_00_00_00, 1'b0);

        // num_bytes == 0 is ignored
        run_pkt(4'd0, 60, -1, 1'b0);
        chki("zero_cslow", c_csl, 0);
        chki("zero_done", c_done, 0);
        chki("zero_busy", c_busy, 0);

        // start while busy and in the done cycle are both ignored
        txb[0] = 8'h3C; txb[1] = 8'h5A; resp[0] = 8'h11; resp[1] = 8'h22;
        run_pkt(4'd2, 2000, 50, 1'b1);
        chki("busy_start_done", c_done, 1);
        chki("busy_start_txreq", c_req, 1);
        chki("busy_start_rxvalid", c_rxv, 2);
        chki("busy_start_cslow", c_csl, 175);
        chk_bytes("busy_start_mosi", 2, 72'h3C_5A_00_00_00_00_00_00_00, 1'b1);
        chk_bytes("busy_start_rx", 2, 72'h11_22_00_00_00_00_00_00_00, 1'b0);
        c_busy = 0; c_csl = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy === 1'b1) c_busy++;
            if (spi_cs === 1'b0) c_csl++;
        end
        chki("done_cycle_start_busy", c_busy, 0);
        chki("done_cycle_start_cs", c_csl, 0);

`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b1; miso_hold0 = 1'b1;
        txb[0] = 8'h5A; txb[1] = 8'hC3; resp[0] = 8'h00; resp[1] = 8'h00;
        run_pkt(4'd2, 2000, -1, 1'b0);
        chki("lb_done", c_done, 1);
        chk_bytes("lb_rx", 2, 72'h5A_C3_00_00_00_00_00_00_00, 1'b0);
        chk_bytes("lb_mosi", 2, 72'h5A_C3_00_00_00_00_00_00_00, 1'b1);
        loopback = 1'b0; miso_hold0 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
